// File: rtl/ram_dump_reader.sv
// Walks the program RAM from FIRST_ADDR to LAST_ADDR (wrapping mod 8) and streams
// each word out over a valid/ready handshake while holding the CPU PC.
module ram_dump_reader #(
  parameter logic [2:0] FIRST_ADDR = 3'b000,
  parameter logic [2:0] LAST_ADDR  = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        PC_Hold,
  output logic [2:0]  RAM_Read_Address,
  input  logic [10:0] RAM_Read_Data,
  output logic        Dump_Valid,
  input  logic        Dump_Ready,
  output logic [10:0] Dump_Data,
  output logic [2:0]  Dump_Address,
  output logic        Dump_Last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] addr;

  function automatic logic [2:0] next_addr(input logic [2:0] a);
    return a + 3'd1;
  endfunction

  assign PC_Hold = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      addr             <= 3'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      RAM_Read_Address <= 3'd0;
      Dump_Valid       <= 1'b0;
      Dump_Data        <= 11'd0;
      Dump_Address     <= 3'd0;
      Dump_Last        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr             <= FIRST_ADDR;
            RAM_Read_Address <= FIRST_ADDR;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        // Address is already on the RAM bus; the word arrives during CAPTURE.
        ISSUE: begin
          RAM_Read_Address <= addr;
          state            <= CAPTURE;
        end
        CAPTURE: begin
          Dump_Data    <= RAM_Read_Data;
          Dump_Address <= addr;
          Dump_Last    <= (addr == LAST_ADDR);
          Dump_Valid   <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (Dump_Ready) begin
            Dump_Valid <= 1'b0;
            Dump_Last  <= 1'b0;
            if (addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr             <= next_addr(addr);
              RAM_Read_Address <= next_addr(addr);
              state            <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
